// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// User-side handshake and SPI pin bundle for spi_master.
interface spi_master_if;
    import spi_pkg::*;

    logic [SPI_WIDTH-1:0] tx_data;
    logic                 tx_start;
    logic [SPI_WIDTH-1:0] rx_data;
    logic                 data_valid;
    logic                 busy;
    logic                 sclk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;

    modport master (
        input  tx_data, tx_start, miso,
        output rx_data, data_valid, busy, sclk, cs, mosi
    );

    modport slave (
        output tx_data, tx_start, miso,
        input  rx_data, data_valid, busy, sclk, cs, mosi
    );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV clocks, restartable via clear.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Tick is not masked by clear so the FSM can use it to decide a clear.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, one byte per transfer, MSB first, SCLK = clk/(2*CLK_DIV).
// Optional back-to-back bursts with CS held low: define SPI_MASTER_BURST_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_if.master     bus
);

    spi_state_e           state;
    logic [SPI_WIDTH-1:0] tx_shift;
    logic [SPI_WIDTH-1:0] rx_shift;
    logic [2:0]           bit_cnt;
    logic                 sclk_q;
    logic                 cs_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 valid_q;
    logic [SPI_WIDTH-1:0] rx_q;

    logic tick;
    logic clear;
    logic burst_acc;

`ifdef SPI_MASTER_BURST_EN
    assign burst_acc = (state == HOLD) && tick && bus.tx_start;
`else
    assign burst_acc = 1'b0;
`endif

    // Counter sits at zero while idle so the first half-period is exactly CLK_DIV long.
    assign clear = (state == IDLE) || burst_acc;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            rx_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_start) begin
                        tx_shift <= bus.tx_data;
                        mosi_q   <= bus.tx_data[SPI_WIDTH-1];
                        cs_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk_q   <= 1'b1;
                        rx_shift <= {rx_shift[SPI_WIDTH-2:0], bus.miso};
                        bit_cnt  <= bit_cnt + 3'd1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q   <= 1'b1;
                            rx_shift <= {rx_shift[SPI_WIDTH-2:0], bus.miso};
                            bit_cnt  <= bit_cnt + 3'd1;
                        end else begin
                            sclk_q <= 1'b0;
                            // bit_cnt wraps to zero on the eighth rising edge.
                            if (bit_cnt == 3'd0) begin
                                state <= HOLD;
                            end else begin
                                tx_shift <= {tx_shift[SPI_WIDTH-2:0], 1'b0};
                                mosi_q   <= tx_shift[SPI_WIDTH-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        rx_q    <= rx_shift;
                        valid_q <= 1'b1;
                        if (burst_acc) begin
                            tx_shift <= bus.tx_data;
                            mosi_q   <= bus.tx_data[SPI_WIDTH-1];
                            state    <= SETUP;
                        end else begin
                            cs_q   <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sclk       = sclk_q;
    assign bus.cs         = cs_q;
    assign bus.mosi       = mosi_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = valid_q;
    assign bus.rx_data    = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: CLK_DIV=2 instance (a) and CLK_DIV=1 instance (b).
module tb_spi_master;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if sif_a ();
    spi_master_if sif_b ();

    spi_master #(.CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(sif_a.master));
    spi_master #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(sif_b.master));

`ifdef SPI_MASTER_BURST_EN
    localparam int   GAP    = 34;
    localparam logic CS_MID = 1'b0;
`else
    localparam int   GAP    = 35;
    localparam logic CS_MID = 1'b1;
`endif

    typedef struct packed {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dv_cnt_a = 0;
    int dv_cnt_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model on instance a: loopback or shift out slv_tx MSB first.
    logic       loop_a = 1'b1;
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         rise_cnt = 0;

    always @(posedge sif_a.sclk) begin
        slv_rx   = {slv_rx[6:0], sif_a.mosi};
        rise_cnt = rise_cnt + 1;
    end

    assign sif_a.miso = loop_a ? sif_a.mosi : slv_tx[3'(7 - (rise_cnt % 8))];
    assign sif_b.miso = sif_b.mosi;

    // Monitors: every data_valid pulse must match the next expected byte and edge.
    always @(negedge clk) begin
        if (sif_a.data_valid === 1'b1) begin
            dv_cnt_a++;
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_rx_data", 32'(sif_a.rx_data), 32'(ea.data));
                check("a_valid_edge", cyc, ea.at);
            end
        end
        if (sif_b.data_valid === 1'b1) begin
            dv_cnt_b++;
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_rx_data", 32'(sif_b.rx_data), 32'(eb.data));
                check("b_valid_edge", cyc, eb.at);
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Returns at the negedge after the accepting edge (cyc == acc).
    task automatic start_a(input logic [7:0] d, output int acc);
        @(negedge clk);
        sif_a.tx_data  = d;
        sif_a.tx_start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        sif_a.tx_start = 1'b0;
        check("a_cs_low_at_start", 32'(sif_a.cs), 32'd0);
        check("a_mosi_bit7_at_start", 32'(sif_a.mosi), 32'(d[7]));
        check("a_busy_at_start", 32'(sif_a.busy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int r0;
        int d0;
        sif_a.tx_data  = 8'h00;
        sif_a.tx_start = 1'b0;
        sif_b.tx_data  = 8'h00;
        sif_b.tx_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cs", 32'(sif_a.cs), 32'd1);
        check("rst_sclk", 32'(sif_a.sclk), 32'd0);
        check("rst_busy", 32'(sif_a.busy), 32'd0);
        check("rst_valid", 32'(sif_a.data_valid), 32'd0);
        check("rst_rx_data", 32'(sif_a.rx_data), 32'h00);
        check("rst_mosi", 32'(sif_a.mosi), 32'd0);
        check("rst_b_cs", 32'(sif_b.cs), 32'd1);

        // Loopback 0xA5, D=2: completes at edge 34.
        r0 = rise_cnt;
        start_a(8'hA5, acc);
        q_a.push_back('{data: 8'hA5, at: acc + 34});
        wait_to(acc + 1);
        check("a_sclk_low_before_D", 32'(sif_a.sclk), 32'd0);
        wait_to(acc + 2);
        check("a_sclk_rise_at_D", 32'(sif_a.sclk), 32'd1);
        wait_to(acc + 33);
        check("a_cs_low_edge33", 32'(sif_a.cs), 32'd0);
        check("a_busy_edge33", 32'(sif_a.busy), 32'd1);
        wait_to(acc + 34);
        check("a_cs_high_edge34", 32'(sif_a.cs), 32'd1);
        check("a_busy_low_edge34", 32'(sif_a.busy), 32'd0);
        check("a_sclk_rises", rise_cnt - r0, 32'd8);
        wait_to(acc + 36);
        check("a_valid_single_pulse", 32'(sif_a.data_valid), 32'd0);

        // Model slave returns 0x3C while master sends 0xFF.
        loop_a = 1'b0;
        slv_tx = 8'h3C;
        start_a(8'hFF, acc);
        q_a.push_back('{data: 8'h3C, at: acc + 34});
        wait_to(acc + 36);
        check("slave_saw_mosi", 32'(slv_rx), 32'hFF);
        loop_a = 1'b1;

        // Extra tx_start pulses during a transfer are ignored.
        d0 = dv_cnt_a;
        start_a(8'h12, acc);
        q_a.push_back('{data: 8'h12, at: acc + 34});
        sif_a.tx_data = 8'h99;
        wait_to(acc + 4);
        sif_a.tx_start = 1'b1;
        @(negedge clk);
        sif_a.tx_start = 1'b0;
        wait_to(acc + 19);
        sif_a.tx_start = 1'b1;
        @(negedge clk);
        sif_a.tx_start = 1'b0;
        wait_to(acc + 40);
        check("ignored_starts_one_byte", dv_cnt_a - d0, 32'd1);
        check("ignored_starts_rx_kept", 32'(sif_a.rx_data), 32'h12);
        check("ignored_starts_idle", 32'(sif_a.busy), 32'd0);

        // Asynchronous reset mid-transfer, then a clean 0x81 transfer.
        start_a(8'h55, acc);
        wait_to(acc + 9);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_cs", 32'(sif_a.cs), 32'd1);
        check("arst_sclk", 32'(sif_a.sclk), 32'd0);
        check("arst_busy", 32'(sif_a.busy), 32'd0);
        check("arst_valid", 32'(sif_a.data_valid), 32'd0);
        check("arst_rx_data", 32'(sif_a.rx_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        start_a(8'h81, acc);
        q_a.push_back('{data: 8'h81, at: acc + 34});
        wait_to(acc + 36);

        // D=1 back-to-back with tx_start held: second byte accepted one clock after busy falls.
        d0 = dv_cnt_b;
        @(negedge clk);
        sif_b.tx_data  = 8'h00;
        sif_b.tx_start = 1'b1;
        acc = cyc + 1;
        q_b.push_back('{data: 8'h00, at: acc + 17});
        q_b.push_back('{data: 8'hFF, at: acc + 35});
        @(negedge clk);
        sif_b.tx_data = 8'hFF;
        wait_to(acc + 1);
        check("b_sclk_high_edge1", 32'(sif_b.sclk), 32'd1);
        wait_to(acc + 2);
        check("b_sclk_low_edge2", 32'(sif_b.sclk), 32'd0);
        wait_to(acc + 17);
        check("b_busy_low_edge17", 32'(sif_b.busy), 32'd0);
        check("b_cs_high_edge17", 32'(sif_b.cs), 32'd1);
        wait_to(acc + 18);
        check("b_busy_edge18", 32'(sif_b.busy), 32'd1);
        check("b_cs_low_edge18", 32'(sif_b.cs), 32'd0);
        check("b_mosi_edge18", 32'(sif_b.mosi), 32'd1);
        sif_b.tx_start = 1'b0;
        wait_to(acc + 40);
        check("b_two_bytes", dv_cnt_b - d0, 32'd2);

        // tx_start held across HOLD end for 0x11, 0x22, 0x33.
        d0 = dv_cnt_a;
        @(negedge clk);
        sif_a.tx_data  = 8'h11;
        sif_a.tx_start = 1'b1;
        acc = cyc + 1;
        q_a.push_back('{data: 8'h11, at: acc + 34});
        q_a.push_back('{data: 8'h22, at: acc + 34 + GAP});
        q_a.push_back('{data: 8'h33, at: acc + 34 + 2 * GAP});
        @(negedge clk);
        sif_a.tx_data = 8'h22;
        wait_to(acc + 34);
        check("chain_cs_after_byte1", 32'(sif_a.cs), 32'(CS_MID));
        wait_to(acc + GAP);
        check("chain_busy_byte2", 32'(sif_a.busy), 32'd1);
        sif_a.tx_data = 8'h33;
        wait_to(acc + 34 + GAP);
        check("chain_cs_after_byte2", 32'(sif_a.cs), 32'(CS_MID));
        wait_to(acc + 2 * GAP);
        sif_a.tx_start = 1'b0;
        wait_to(acc + 34 + 2 * GAP + 3);
        check("chain_three_bytes", dv_cnt_a - d0, 32'd3);
        check("chain_cs_end", 32'(sif_a.cs), 32'd1);
        check("chain_busy_end", 32'(sif_a.busy), 32'd0);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
